bird_datapath: RTL and testbench
================================

// Module: bird_datapath
// PURPOSE
//  Datapath directly downstream of the bird control FSM: consumes its 5-bit state, owns bird y/velocity,
//  returns flag (rise height reached) and touched (screen-edge hit), drives VGA pixel writes.
//  Per frame it erases the old sprite and draws the new one, then updates position and velocity.
// PARAMETERS
//  X_POS 20 bird left column; SIZE 4 sprite edge in pixels (2*SIZE*SIZE <= 128); Y_START 60 spawn row
//  SCREEN_H 120 visible rows; RISE_HEIGHT 16 rows climbed before flag; FLAP_VY -3 signed rows/frame while rising
//  GRAVITY 1 rows/frame^2 added while falling; MAX_VY 4 terminal fall speed; BIRD_COL 3'b110; BG_COL 3'b000
// PORTS
//  clk      in   1  system clock
//  reset    in   1  synchronous, active-high
//  state    in   5  control FSM state
//  vga_x    out  8  pixel column
//  vga_y    out  7  pixel row
//  colour   out  3  pixel colour
//  plot     out  1  pixel write strobe, one pixel per cycle
//  flag     out  1  climbed >= RISE_HEIGHT since rise began
//  touched  out  1  bird hit floor (or ceiling, see CONFIGURATION); sticky
//  bird_y   out  7  current top row of sprite
// BEHAVIOUR
//  Reset: vga_x/vga_y/colour/plot/flag/touched=0, y=Y_START, vy=0, drawn_y=Y_START, mode=START, anchor invalid.
//  mode register: loaded with state whenever state is START, RAISING or FALLING; other states hold it.
//  START (state 0): y=Y_START, vy=0, flag=0, touched=0, anchor invalid; no plotting.
//  DRAW (state 4), held 129 cycles by control: sweep counter k restarts to 0 on first DRAW cycle.
//   k in [0,SIZE^2): erase pixel (X_POS+k%SIZE, drawn_y+k/SIZE), colour=BG_COL, plot=1.
//   k in [SIZE^2,2*SIZE^2): draw same offsets at y, colour=BIRD_COL, plot=1; then plot=0, idle.
//   outputs registered: pixel k appears on ports the cycle after k is issued.
//  DEL (state 15): drawn_y <= y only if draw sweep completed; else drawn_y held.
//  UPDATE (14): ny = y + vy as 8-bit signed; ny<0 -> y=0; ny>SCREEN_H-SIZE -> y=SCREEN_H-SIZE, touched=1 (floor).
//   mode RAISING and anchor invalid: anchor_y=y (pre-update), anchor valid. mode!=RAISING: anchor invalid.
//  UPDATE_VY (11): RAISING vy=FLAP_VY; FALLING vy=min(vy+GRAVITY,MAX_VY); START vy=0.
//  flag = mode==RAISING && anchor valid && (anchor_y - y) >= RISE_HEIGHT, registered, updated in UPDATE_VY.
//  touched sticky until START or reset. STOP (3) and unknown codes: hold all registers, plot=0.
//  State leaves DRAW mid-sweep: sweep aborted, plot=0 next cycle. Reset mid-sweep: same, plus reset values.
//  Ceiling clamp (y=0) while rising: flag forced 1 so control turns to FALLING.
// CONFIGURATION
//  BIRD_CEIL_HIT_EN defined: ny<0 also sets touched=1 (ceiling kills).
//  Not defined: ceiling only clamps to y=0 and forces flag; touched from floor only.
// STRUCTURE
//  Shared package bird_pkg: 5-bit state localparams (B_START..B_UPDATE_VY) shared with control_bird, colour constants.
//  One sub-module: bird_sprite_sweep (counter k, erase/draw phase, offsets, done) instanced once.
//  Position/velocity/flag/touched logic stays in bird_datapath.
// TESTING
//  1 reset 3 cycles, state=START -> plot=0, bird_y=60, flag=0, touched=0.
//  2 DRAW 129 cycles after reset -> 16 BG pixels at (20..23,60..63), then 16 BIRD_COL pixels same coords, then plot=0.
//  3 RAISING frames (DRAW,DEL,UPDATE,UPDATE_VY) from y=60 -> y 60,57,54,... flag=1 after frame with y<=44.
//  4 FALLING from vy=0, y=40 -> vy 1,2,3,4,4; y advances by previous vy; reaches 116 -> touched=1, held until START.
//  5 state DRAW->DEL at cycle 10 of sweep -> plot=0 next cycle, drawn_y unchanged, next DRAW erases old position.
//  6 RAISING at y=2, vy=-3 -> y=0, flag=1; touched=1 only with BIRD_CEIL_HIT_EN.

Source files
------------

// File: rtl/bird_pkg.sv
// ============================================================================
//  Module      : bird_pkg
//  Description : Shared definitions for the bird control FSM and the bird
//                datapath: 5-bit control state codes, sprite colours and the
//                sweep phase type used by the sprite sweeper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bird_pkg;

  // Control FSM state codes (5-bit, shared with control_bird).
  localparam logic [4:0] B_START     = 5'd0;
  localparam logic [4:0] B_RAISING   = 5'd1;
  localparam logic [4:0] B_FALLING   = 5'd2;
  localparam logic [4:0] B_STOP      = 5'd3;
  localparam logic [4:0] B_DRAW      = 5'd4;
  localparam logic [4:0] B_UPDATE_VY = 5'd11;
  localparam logic [4:0] B_UPDATE    = 5'd14;
  localparam logic [4:0] B_DEL       = 5'd15;

  // Pixel colours.
  localparam logic [2:0] C_BIRD_COL = 3'b110;
  localparam logic [2:0] C_BG_COL   = 3'b000;

  // Which half of the per-frame sweep a pixel belongs to.
  typedef enum logic [0:0] {
    PH_ERASE = 1'b0,
    PH_DRAW  = 1'b1
  } sweep_phase_e;

endpackage : bird_pkg

`default_nettype wire

// File: rtl/bird_datapath_if.sv
// ============================================================================
//  Module      : bird_datapath_if
//  Description : Bus between the bird control FSM (master) and the bird
//                datapath (slave).
//                state   : control FSM state, master -> slave
//                vga_x   : pixel column
//                vga_y   : pixel row
//                colour  : pixel colour
//                plot    : pixel write strobe
//                flag    : rise height reached
//                touched : screen edge hit (sticky)
//                bird_y  : current top row of the sprite
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bird_datapath_if;
  logic [4:0] state;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       flag;
  logic       touched;
  logic [6:0] bird_y;

  modport master (
    output state,
    input  vga_x, vga_y, colour, plot, flag, touched, bird_y
  );

  modport slave (
    input  state,
    output vga_x, vga_y, colour, plot, flag, touched, bird_y
  );
endinterface : bird_datapath_if

`default_nettype wire

// File: rtl/bird_sprite_sweep.sv
// ============================================================================
//  Module      : bird_sprite_sweep
//  Description : Per-frame sprite sweep counter. While i_run is high it issues
//                one pixel index per cycle: first SIZE*SIZE erase offsets,
//                then SIZE*SIZE draw offsets, then idles. The count restarts
//                on the first cycle of every run; dropping i_run aborts it.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                i_run       - sweep enable (control in DRAW)
//                o_active    - a pixel is issued this cycle
//                o_phase     - erase or draw half of the sweep
//                o_dx, o_dy  - pixel offset within the sprite
//                o_done      - all pixels of the current/last run issued
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_sprite_sweep
  import bird_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_run,
  output logic              o_active,
  output sweep_phase_e      o_phase,
  output logic [7:0]        o_dx,
  output logic [6:0]        o_dy,
  output logic              o_done
);

  localparam int KW = $clog2(2 * SIZE * SIZE + 1);
  localparam logic [KW-1:0] c_size  = KW'(SIZE);
  localparam logic [KW-1:0] c_area  = KW'(SIZE * SIZE);
  localparam logic [KW-1:0] c_total = KW'(2 * SIZE * SIZE);

  logic [KW-1:0] r_k;
  logic          r_run_d;
  logic          r_done;
  logic [KW-1:0] w_k;
  logic [KW-1:0] w_idx;

  always_comb begin
    // First cycle of a run always starts at index 0, whatever r_k holds.
    w_k      = r_run_d ? r_k : '0;
    o_active = i_run && (w_k < c_total);
    o_phase  = (w_k >= c_area) ? PH_DRAW : PH_ERASE;
    w_idx    = (o_phase == PH_DRAW) ? (w_k - c_area) : w_k;
    o_dx     = 8'(w_idx % c_size);
    o_dy     = 7'(w_idx / c_size);
    o_done   = r_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_run_d <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_run_d <= i_run;
      if (o_active) begin
        r_k <= w_k + 1'b1;
      end
      if (o_active && (w_k == c_total - 1'b1)) begin
        r_done <= 1'b1;
      end else if (i_run && !r_run_d) begin
        r_done <= 1'b0;
      end
    end
  end

endmodule : bird_sprite_sweep

`default_nettype wire

// File: rtl/bird_datapath.sv
// ============================================================================
//  Module      : bird_datapath
//  Description : Bird datapath behind the bird control FSM. Owns bird row and
//                vertical velocity, erases/draws the sprite each frame over
//                the VGA pixel port, and reports flag (rise height reached)
//                and touched (screen edge hit, sticky).
//  Ports       : clk    - system clock
//                reset  - synchronous, active-high
//                bus    - bird_datapath_if.slave (state in; vga_x, vga_y,
//                         colour, plot, flag, touched, bird_y out)
//  Config      : BIRD_CEIL_HIT_EN - when defined, hitting the ceiling also
//                sets touched. Default: ceiling only clamps and forces flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_datapath
  import bird_pkg::*;
#(
  parameter int         X_POS       = 20,
  parameter int         SIZE        = 4,
  parameter int         Y_START     = 60,
  parameter int         SCREEN_H    = 120,
  parameter int         RISE_HEIGHT = 16,
  parameter int         FLAP_VY     = -3,
  parameter int         GRAVITY     = 1,
  parameter int         MAX_VY      = 4,
  parameter logic [2:0] BIRD_COL    = C_BIRD_COL,
  parameter logic [2:0] BG_COL      = C_BG_COL
) (
  input  wire logic   clk,
  input  wire logic   reset,
  bird_datapath_if.slave bus
);

  localparam logic [7:0]        c_x_pos   = 8'(X_POS);
  localparam logic [6:0]        c_y_start = 7'(Y_START);
  localparam logic [6:0]        c_floor_y = 7'(SCREEN_H - SIZE);
  localparam logic signed [7:0] c_floor_s = 8'(SCREEN_H - SIZE);
  localparam logic signed [7:0] c_rise    = 8'(RISE_HEIGHT);
  localparam logic signed [7:0] c_flap_vy = 8'(FLAP_VY);
  localparam logic signed [7:0] c_gravity = 8'(GRAVITY);
  localparam logic signed [7:0] c_max_vy  = 8'(MAX_VY);

  // Bird state
  logic [6:0]        r_y;
  logic signed [7:0] r_vy;
  logic [6:0]        r_drawn_y;
  logic [4:0]        r_mode;
  logic [6:0]        r_anchor_y;
  logic              r_anchor_v;
  logic              r_flag;
  logic              r_touched;
  logic              r_ceil;

  // Registered pixel port
  logic [7:0]        r_vga_x;
  logic [6:0]        r_vga_y;
  logic [2:0]        r_colour;
  logic              r_plot;

  // Sweep
  logic              w_sw_active;
  sweep_phase_e      w_sw_phase;
  logic [7:0]        w_sw_dx;
  logic [6:0]        w_sw_dy;
  logic              w_sw_done;

  // Position/velocity arithmetic
  logic signed [7:0] w_ny;
  logic              w_ny_neg;
  logic              w_ny_floor;
  logic signed [7:0] w_climb;
  logic signed [7:0] w_vy_inc;
  logic signed [7:0] w_vy_fall;
  logic              w_load_mode;

  bird_sprite_sweep #(
    .SIZE (SIZE)
  ) u_sweep (
    .clk      (clk),
    .reset    (reset),
    .i_run    (bus.state == B_DRAW),
    .o_active (w_sw_active),
    .o_phase  (w_sw_phase),
    .o_dx     (w_sw_dx),
    .o_dy     (w_sw_dy),
    .o_done   (w_sw_done)
  );

  always_comb begin
    // Row 0..116 plus velocity -3..4 always fits in 8-bit signed.
    w_ny        = $signed({1'b0, r_y}) + r_vy;
    w_ny_neg    = (w_ny < 0);
    w_ny_floor  = (w_ny > c_floor_s);
    w_climb     = $signed({1'b0, r_anchor_y}) - $signed({1'b0, r_y});
    w_vy_inc    = r_vy + c_gravity;
    w_vy_fall   = (w_vy_inc > c_max_vy) ? c_max_vy : w_vy_inc;
    w_load_mode = (bus.state == B_START) || (bus.state == B_RAISING) ||
                  (bus.state == B_FALLING);
  end

  // Pixel port: the pixel issued this cycle appears on the port next cycle.
  // Any cycle without an issued pixel (abort, idle, other states) drops plot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_plot <= w_sw_active;
      if (w_sw_active) begin
        r_vga_x <= c_x_pos + w_sw_dx;
        if (w_sw_phase == PH_DRAW) begin
          r_vga_y  <= r_y + w_sw_dy;
          r_colour <= BIRD_COL;
        end else begin
          r_vga_y  <= r_drawn_y + w_sw_dy;
          r_colour <= BG_COL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y        <= c_y_start;
      r_vy       <= '0;
      r_drawn_y  <= c_y_start;
      r_mode     <= B_START;
      r_anchor_y <= '0;
      r_anchor_v <= 1'b0;
      r_flag     <= 1'b0;
      r_touched  <= 1'b0;
      r_ceil     <= 1'b0;
    end else begin
      if (w_load_mode) begin
        r_mode <= bus.state;
      end
      case (bus.state)
        B_START: begin
          r_y        <= c_y_start;
          r_vy       <= '0;
          r_flag     <= 1'b0;
          r_touched  <= 1'b0;
          r_anchor_v <= 1'b0;
          r_ceil     <= 1'b0;
        end
        B_DEL: begin
          // An aborted sweep left the old sprite partly on screen, so the
          // next erase must still target the old row.
          if (w_sw_done) begin
            r_drawn_y <= r_y;
          end
        end
        B_UPDATE: begin
          r_ceil <= w_ny_neg;
          if (w_ny_neg) begin
            r_y <= '0;
`ifdef BIRD_CEIL_HIT_EN
            r_touched <= 1'b1;
`endif
          end else if (w_ny_floor) begin
            r_y       <= c_floor_y;
            r_touched <= 1'b1;
          end else begin
            r_y <= w_ny[6:0];
          end
          // Anchor marks the row where the current climb started.
          if (r_mode == B_RAISING) begin
            if (!r_anchor_v) begin
              r_anchor_y <= r_y;
              r_anchor_v <= 1'b1;
            end
          end else begin
            r_anchor_v <= 1'b0;
          end
        end
        B_UPDATE_VY: begin
          case (r_mode)
            B_RAISING: r_vy <= c_flap_vy;
            B_FALLING: r_vy <= w_vy_fall;
            B_START:   r_vy <= '0;
            default:   r_vy <= r_vy;
          endcase
          // A ceiling clamp while climbing also raises flag so control
          // turns the bird around.
          r_flag <= (r_mode == B_RAISING) &&
                    ((r_anchor_v && (w_climb >= c_rise)) || r_ceil);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.vga_x   = r_vga_x;
  assign bus.vga_y   = r_vga_y;
  assign bus.colour  = r_colour;
  assign bus.plot    = r_plot;
  assign bus.flag    = r_flag;
  assign bus.touched = r_touched;
  assign bus.bird_y  = r_y;

endmodule : bird_datapath

`default_nettype wire

// File: tb/tb_bird_datapath.sv
// ============================================================================
//  Module      : tb_bird_datapath
//  Description : Self-checking bench for bird_datapath. A frame-level model
//                (pixel queue per DRAW, plain integer position/velocity
//                rules) is compared with the DUT on every cycle, and a few
//                hand-computed literals pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bird_datapath;
  import bird_pkg::*;

`ifdef BIRD_CEIL_HIT_EN
  localparam int CEIL_KILLS = 1;
`else
  localparam int CEIL_KILLS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bird_datapath_if bif ();

  bird_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int checks = 0;
  int failures = 0;
  int plot_count = 0;
  bit cmp_en = 1'b0;

  // ---------------- model ----------------
  typedef struct {
    int x;
    int y;
    int col;
  } pix_t;

  pix_t m_q[$];
  int m_y, m_vy, m_drawn, m_mode, m_anchor, m_anchor_v;
  int m_flag, m_touched, m_ceil, m_done, m_prev_draw;
  int m_x_o, m_y_o, m_col_o, m_plot_o;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input int st);
    int   ny;
    pix_t p;
    if (rst) begin
      m_y = 60; m_vy = 0; m_drawn = 60; m_mode = 0; m_anchor = 0; m_anchor_v = 0;
      m_flag = 0; m_touched = 0; m_ceil = 0; m_done = 0; m_prev_draw = 0;
      m_q.delete();
      m_x_o = 0; m_y_o = 0; m_col_o = 0; m_plot_o = 0;
      return;
    end
    m_plot_o = 0;
    if (st == 0 || st == 1 || st == 2) m_mode = st;
    if (st == 4) begin
      if (!m_prev_draw) begin
        m_q.delete();
        m_done = 0;
        for (int ph = 0; ph < 2; ph++)
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
              p.x   = 20 + c;
              p.y   = (ph == 1 ? m_y : m_drawn) + r;
              p.col = (ph == 1) ? 6 : 0;
              m_q.push_back(p);
            end
      end
      if (m_q.size() > 0) begin
        p = m_q.pop_front();
        m_x_o = p.x; m_y_o = p.y; m_col_o = p.col; m_plot_o = 1;
        if (m_q.size() == 0) m_done = 1;
      end
    end else begin
      m_q.delete();
    end
    case (st)
      0: begin
        m_y = 60; m_vy = 0; m_flag = 0; m_touched = 0; m_anchor_v = 0; m_ceil = 0;
      end
      15: if (m_done) m_drawn = m_y;
      14: begin
        ny = m_y + m_vy;
        if (m_mode == 1) begin
          if (!m_anchor_v) begin m_anchor = m_y; m_anchor_v = 1; end
        end else m_anchor_v = 0;
        m_ceil = (ny < 0) ? 1 : 0;
        if (ny < 0) begin
          m_y = 0;
          if (CEIL_KILLS == 1) m_touched = 1;
        end else if (ny > 116) begin
          m_y = 116; m_touched = 1;
        end else m_y = ny;
      end
      11: begin
        if (m_mode == 1) m_vy = -3;
        else if (m_mode == 2) m_vy = (m_vy + 1 > 4) ? 4 : m_vy + 1;
        else if (m_mode == 0) m_vy = 0;
        m_flag = (m_mode == 1 && ((m_anchor_v == 1 && m_anchor - m_y >= 16) || m_ceil == 1)) ? 1 : 0;
      end
      default: ;
    endcase
    m_prev_draw = (st == 4) ? 1 : 0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("plot",    int'(bif.plot),    m_plot_o);
      chk("vga_x",   int'(bif.vga_x),   m_x_o);
      chk("vga_y",   int'(bif.vga_y),   m_y_o);
      chk("colour",  int'(bif.colour),  m_col_o);
      chk("bird_y",  int'(bif.bird_y),  m_y);
      chk("flag",    int'(bif.flag),    m_flag);
      chk("touched", int'(bif.touched), m_touched);
      if (bif.plot) plot_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input int st);
    reset     = rst;
    bif.state = 5'(st);
    @(posedge clk);
    model_edge(rst, st);
    @(negedge clk);
  endtask

  task automatic frame(input int mode_st);
    cyc(1'b0, mode_st);
    repeat (129) cyc(1'b0, 4);
    cyc(1'b0, 15);
    cyc(1'b0, 14);
    cyc(1'b0, 11);
  endtask

  initial begin
    reset     = 1'b1;
    bif.state = 5'd0;
    @(negedge clk);

    // 1: reset, state START
    cyc(1'b1, 0);
    cmp_en = 1'b1;
    cyc(1'b1, 0);
    cyc(1'b1, 0);
    chk("rst_plot",    int'(bif.plot),    0);
    chk("rst_bird_y",  int'(bif.bird_y),  60);
    chk("rst_flag",    int'(bif.flag),    0);
    chk("rst_touched", int'(bif.touched), 0);
    cyc(1'b0, 0);

    // 2: one full DRAW sweep
    plot_count = 0;
    cyc(1'b0, 4);
    chk("first_erase_x",   int'(bif.vga_x),  20);
    chk("first_erase_y",   int'(bif.vga_y),  60);
    chk("first_erase_col", int'(bif.colour), 0);
    repeat (15) cyc(1'b0, 4);
    cyc(1'b0, 4);
    chk("first_draw_x",   int'(bif.vga_x),  20);
    chk("first_draw_y",   int'(bif.vga_y),  60);
    chk("first_draw_col", int'(bif.colour), 6);
    repeat (112) cyc(1'b0, 4);
    chk("sweep_idle_plot", int'(bif.plot), 0);
    chk("sweep_pixels",    plot_count,     32);
    cyc(1'b0, 15);
    cyc(1'b0, 14);
    cyc(1'b0, 11);

    // 3: rising from 60
    cyc(1'b0, 0);
    repeat (6) frame(1);
    chk("rise6_y",    int'(bif.bird_y), 45);
    chk("rise6_flag", int'(bif.flag),   0);
    frame(1);
    chk("rise7_y",    int'(bif.bird_y), 42);
    chk("rise7_flag", int'(bif.flag),   1);

    // 4: falling to the floor
    repeat (25) frame(2);
    chk("fall25_y",       int'(bif.bird_y),  114);
    chk("fall25_touched", int'(bif.touched), 0);
    frame(2);
    chk("fall26_y",       int'(bif.bird_y),  116);
    chk("fall26_touched", int'(bif.touched), 1);
    repeat (3) cyc(1'b0, 3);
    repeat (2) cyc(1'b0, 9);
    chk("stop_touched", int'(bif.touched), 1);
    frame(2);
    chk("floor_hold_y", int'(bif.bird_y), 116);
    cyc(1'b0, 0);
    chk("start_touched", int'(bif.touched), 0);
    chk("start_y",       int'(bif.bird_y),  60);

    // 5: sweep aborted after 10 cycles
    repeat (10) cyc(1'b0, 4);
    cyc(1'b0, 15);
    chk("abort_plot", int'(bif.plot), 0);
    cyc(1'b0, 14);
    cyc(1'b0, 11);
    cyc(1'b0, 4);
    chk("abort_erase_old_y", int'(bif.vga_y), 116);
    repeat (128) cyc(1'b0, 4);
    cyc(1'b0, 15);
    cyc(1'b0, 14);
    cyc(1'b0, 11);

    // 6: rising into the ceiling
    cyc(1'b0, 0);
    frame(1); frame(2); frame(1); frame(2);
    repeat (17) frame(1);
    chk("ceil_pre_y", int'(bif.bird_y), 2);
    frame(1);
    chk("ceil_y",       int'(bif.bird_y),  0);
    chk("ceil_flag",    int'(bif.flag),    1);
    chk("ceil_touched", int'(bif.touched), CEIL_KILLS);
    frame(2);
    chk("ceil_fall_flag", int'(bif.flag), 0);
    frame(1);
    chk("ceil_only_flag", int'(bif.flag),   1);
    chk("ceil_only_y",    int'(bif.bird_y), 0);

    // reset in the middle of a sweep
    cyc(1'b0, 0);
    repeat (5) cyc(1'b0, 4);
    cyc(1'b1, 4);
    chk("rst_mid_plot", int'(bif.plot),   0);
    chk("rst_mid_y",    int'(bif.bird_y), 60);
    cyc(1'b0, 0);
    cyc(1'b0, 4);
    chk("rst_restart_erase_y", int'(bif.vga_y), 60);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bird_datapath

`default_nettype wire
